// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table, reader FSM states and pattern-to-nibble helper
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  // Entry i is the segment pattern E[6:0] that displays hex digit i.
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0011011, 7'b1011011, 7'b1111100, 7'b1010011,
    7'b1111010, 7'b0111111, 7'b1101111, 7'b1111111,
    7'b0100101, 7'b1111011, 7'b1101011, 7'b0101110,
    7'b1101101, 7'b1011101, 7'b0100100, 7'b1110111
  };

  function automatic logic [4:0] seg7_to_hex(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b1_0000;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPHS[i]) r = {1'b0, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_lookup.sv
// rtl/seg7_glyph_lookup.sv - combinational segment pattern to {illegal, nibble} map
module seg7_glyph_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic       illegal,
  output logic [3:0] nibble
);

  always_comb begin
    {illegal, nibble} = seg7_to_hex(seg_in);
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - assembles strobed seven-segment digits into a word with valid/ready output
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic                seg_strobe,
  input  logic                frame_start,
  output logic [4*DIGITS-1:0] out_value,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  localparam int CW = $clog2(DIGITS) + 1;
  localparam int W  = 4 * DIGITS;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    value_q, value_d;
  logic            err_q, err_d;
  logic            overrun_q, overrun_d;
  logic [3:0]      nib;
  logic            illegal;
  logic            start;
  logic            store;

  seg7_glyph_lookup u_lookup (
    .seg_in  (seg_in),
    .illegal (illegal),
    .nibble  (nib)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    value_d   = value_q;
    err_d     = err_q;
    overrun_d = 1'b0;
    start     = 1'b0;
    store     = 1'b0;

    case (state_q)
      IDLE: start = seg_strobe & frame_start;
      COLLECT: begin
        start = seg_strobe & frame_start;
        store = seg_strobe & ~frame_start;
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = IDLE;
          start     = seg_strobe & frame_start;
          overrun_d = seg_strobe & ~frame_start;
        end else begin
          overrun_d = seg_strobe;
        end
      end
      default: state_d = IDLE;
    endcase

    // Digits shift in from the bottom so the first one ends up most significant.
    if (start) begin
      value_d = W'(nib);
      err_d   = illegal;
      count_d = CW'(1);
      state_d = (DIGITS == 1) ? HOLD : COLLECT;
    end else if (store) begin
      value_d = (value_q << 4) | W'(nib);
      err_d   = err_q | illegal;
      count_d = count_q + 1'b1;
      if (count_d == CW'(DIGITS)) state_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      value_q   <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      value_q   <= value_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_value = value_q;
  assign out_err   = err_q;
  assign out_valid = (state_q == HOLD);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - directed vectors, random model check and single-digit sweep for seg7_reader
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic        seg_strobe = 1'b0;
  logic        frame_start = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_value;
  logic        out_err, out_valid, overrun;

  logic [6:0]  seg1 = '0;
  logic        strobe1 = 1'b0, fs1 = 1'b0, ready1 = 1'b0;
  logic [3:0]  value1;
  logic        err1, valid1, ovr1;

  int total = 0;
  int bad = 0;

  logic [6:0] G [16] = '{7'b1110111, 7'b0100100, 7'b1011101, 7'b1101101,
                         7'b0101110, 7'b1101011, 7'b1111011, 7'b0100101,
                         7'b1111111, 7'b1101111, 7'b0111111, 7'b1111010,
                         7'b1010011, 7'b1111100, 7'b1011011, 7'b0011011};

  seg7_reader #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_strobe(seg_strobe),
    .frame_start(frame_start), .out_value(out_value), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  seg7_reader #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .seg_in(seg1), .seg_strobe(strobe1),
    .frame_start(fs1), .out_value(value1), .out_err(err1),
    .out_valid(valid1), .out_ready(ready1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  // Reference: a frame is a list of decoded digits; a full list becomes the held word.
  bit          m_held, m_coll, m_derr, m_err, m_ovr;
  logic [15:0] m_word;
  int          m_q[$];

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++) if (G[i] == p) r = {1'b0, 4'(i)};
    return r;
  endfunction

  task automatic model_reset();
    m_held = 0; m_coll = 0; m_derr = 0; m_err = 0; m_ovr = 0; m_word = '0;
    m_q.delete();
  endtask

  task automatic add_digit(input logic [4:0] d);
    m_q.push_back(int'(d[3:0]));
    m_derr = m_derr | d[4];
    if (m_q.size() == 4) begin
      m_held = 1; m_coll = 0; m_err = m_derr; m_word = '0;
      foreach (m_q[i]) m_word = (m_word << 4) | 16'(m_q[i]);
    end
  endtask

  task automatic begin_frame(input logic [4:0] d);
    m_coll = 1; m_derr = 0;
    m_q.delete();
    add_digit(d);
  endtask

  task automatic model_step(input logic s, input logic fs, input logic [6:0] seg, input logic rdy);
    logic [4:0] d;
    d = ref_dec(seg);
    m_ovr = 0;
    if (m_held) begin
      if (rdy) begin
        m_held = 0;
        if (s && fs) begin_frame(d);
        else if (s) m_ovr = 1;
      end else if (s) begin
        m_ovr = 1;
      end
    end else if (s) begin
      if (fs) begin_frame(d);
      else if (m_coll) add_digit(d);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic fs, input logic [6:0] seg, input logic rdy);
    seg_strobe = s; frame_start = fs; seg_in = seg; out_ready = rdy;
    @(posedge clk);
    model_step(s, fs, seg, rdy);
    #1;
    chk("model_valid", 32'(out_valid), 32'(m_held));
    if (m_held) begin
      chk("model_value", 32'(out_value), 32'(m_word));
      chk("model_err", 32'(out_err), 32'(m_err));
    end
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    seg_strobe = 0; frame_start = 0; seg_in = '0; out_ready = 0;
    strobe1 = 0; fs1 = 0; seg1 = '0; ready1 = 0;
    @(posedge clk);
    #1;
    chk({nm, "_value"}, 32'(out_value), 0);
    chk({nm, "_err"}, 32'(out_err), 0);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_overrun"}, 32'(overrun), 0);
    chk({nm, "_valid1"}, 32'(valid1), 0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        s, fs;
    logic [6:0]  seg;
    logic        rdy;
    logic        ev;
    logic [15:0] eval;
    logic        eerr;
    logic        eovr;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic s, input logic fs, input logic [6:0] seg, input logic rdy,
                      input logic ev, input logic [15:0] eval, input logic eerr, input logic eovr);
    vec_t v;
    v.s = s; v.fs = fs; v.seg = seg; v.rdy = rdy;
    v.ev = ev; v.eval = eval; v.eerr = eerr; v.eovr = eovr;
    vt.push_back(v);
  endtask

  initial begin
    do_reset("reset");

    // Basic frame, immediate accept: valid for exactly one cycle.
    addv(1, 1, G[0], 1, 0, 0, 0, 0);
    addv(1, 0, G[1], 1, 0, 0, 0, 0);
    addv(1, 0, G[2], 1, 0, 0, 0, 0);
    addv(1, 0, G[3], 1, 1, 16'h0123, 0, 0);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);
    // Backpressure: held stable, then transferred.
    addv(1, 1, G[10], 0, 0, 0, 0, 0);
    addv(1, 0, G[11], 0, 0, 0, 0, 0);
    addv(1, 0, G[12], 0, 0, 0, 0, 0);
    addv(1, 0, G[15], 0, 1, 16'hABCF, 0, 0);
    for (int i = 0; i < 4; i++) addv(0, 0, 7'h0, 0, 1, 16'hABCF, 0, 0);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);
    // Illegal third digit, then a clean frame clears the error.
    addv(1, 1, G[0], 1, 0, 0, 0, 0);
    addv(1, 0, G[1], 1, 0, 0, 0, 0);
    addv(1, 0, 7'h00, 1, 0, 0, 0, 0);
    addv(1, 0, G[3], 1, 1, 16'h0103, 1, 0);
    addv(1, 1, G[0], 1, 0, 0, 0, 0);
    addv(1, 0, G[1], 1, 0, 0, 0, 0);
    addv(1, 0, G[2], 1, 0, 0, 0, 0);
    addv(1, 0, G[3], 1, 1, 16'h0123, 0, 0);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);
    // Overruns while holding.
    addv(1, 1, G[4], 0, 0, 0, 0, 0);
    addv(1, 0, G[5], 0, 0, 0, 0, 0);
    addv(1, 0, G[6], 0, 0, 0, 0, 0);
    addv(1, 0, G[7], 0, 1, 16'h4567, 0, 0);
    addv(1, 0, G[1], 0, 1, 16'h4567, 0, 1);
    addv(0, 0, 7'h0, 0, 1, 16'h4567, 0, 0);
    addv(1, 1, G[2], 0, 1, 16'h4567, 0, 1);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);
    // Transfer with a non-start strobe: dropped, overrun.
    addv(1, 1, G[8], 0, 0, 0, 0, 0);
    addv(1, 0, G[9], 0, 0, 0, 0, 0);
    addv(1, 0, G[10], 0, 0, 0, 0, 0);
    addv(1, 0, G[11], 0, 1, 16'h89AB, 0, 0);
    addv(1, 0, G[0], 1, 0, 0, 0, 1);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);
    // Idle strobes without frame_start are ignored.
    addv(1, 0, G[5], 1, 0, 0, 0, 0);
    addv(1, 0, G[6], 1, 0, 0, 0, 0);
    // Mid-frame restart discards the partial frame and its error.
    addv(1, 1, 7'h00, 1, 0, 0, 0, 0);
    addv(1, 0, G[1], 1, 0, 0, 0, 0);
    addv(1, 1, G[8], 1, 0, 0, 0, 0);
    addv(1, 0, G[9], 1, 0, 0, 0, 0);
    addv(1, 0, G[14], 1, 0, 0, 0, 0);
    addv(1, 0, G[15], 1, 1, 16'h89EF, 0, 0);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);
    // New frame starts on the transfer cycle.
    addv(1, 1, G[12], 0, 0, 0, 0, 0);
    addv(1, 0, G[13], 0, 0, 0, 0, 0);
    addv(1, 0, G[14], 0, 0, 0, 0, 0);
    addv(1, 0, G[15], 0, 1, 16'hCDEF, 0, 0);
    addv(1, 1, G[7], 1, 0, 0, 0, 0);
    addv(1, 0, G[1], 1, 0, 0, 0, 0);
    addv(1, 0, G[2], 1, 0, 0, 0, 0);
    addv(1, 0, G[3], 1, 1, 16'h7123, 0, 0);
    addv(0, 0, 7'h0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].s, vt[i].fs, vt[i].seg, vt[i].rdy);
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("row%0d_value", i), 32'(out_value), 32'(vt[i].eval));
        chk($sformatf("row%0d_err", i), 32'(out_err), 32'(vt[i].eerr));
      end
      chk($sformatf("row%0d_overrun", i), 32'(overrun), 32'(vt[i].eovr));
    end

    // Reset two digits into a frame, then a full frame.
    cyc(1, 1, G[3], 1);
    cyc(1, 0, G[4], 1);
    do_reset("midframe_rst");
    cyc(1, 1, G[8], 1);
    cyc(1, 0, G[9], 1);
    cyc(1, 0, G[14], 1);
    cyc(1, 0, G[15], 1);
    chk("post_rst_value", 32'(out_value), 32'h89EF);
    chk("post_rst_valid", 32'(out_valid), 1);
    cyc(0, 0, 7'h0, 1);

    // Reset while holding a word.
    cyc(1, 1, G[1], 0);
    cyc(1, 0, G[2], 0);
    cyc(1, 0, G[3], 0);
    cyc(1, 0, G[4], 0);
    chk("hold_before_rst", 32'(out_valid), 1);
    do_reset("hold_rst");

    // Random traffic against the reference.
    for (int i = 0; i < 800; i++) begin
      logic s, fs, rdy;
      logic [6:0] seg;
      s   = ($urandom_range(0, 3) != 0);
      fs  = s && ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      seg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : G[$urandom_range(0, 15)];
      cyc(s, fs, seg, rdy);
    end
    cyc(0, 0, 7'h0, 1);

    // Single-digit instance: every glyph, back to back, accepted each cycle.
    for (int i = 0; i < 16; i++) begin
      strobe1 = 1; fs1 = 1; seg1 = G[i]; ready1 = 1;
      @(posedge clk);
      #1;
      chk($sformatf("d1_valid%0d", i), 32'(valid1), 1);
      chk($sformatf("d1_value%0d", i), 32'(value1), 32'(i));
      chk($sformatf("d1_err%0d", i), 32'(err1), 0);
      chk($sformatf("d1_overrun%0d", i), 32'(ovr1), 0);
    end
    strobe1 = 0; fs1 = 0;
    @(posedge clk);
    #1;
    chk("d1_final_valid", 32'(valid1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
